carrier_accumulator: RTL and testbench
======================================

# carrier_accumulator

Integrate-and-dump stage fed by the carrier wipe-off multiplier in each tracking channel. Each cycle with `sample_valid` high, the block takes one 5-bit sign-magnitude product and converts it to two's complement. It adds the result into a saturating running sum. On each `dump` strobe (code-epoch boundary) it latches the sum into a held result register for the correlator-readout logic, then restarts from zero.

## Interface
Parameters:
- `ACC_WIDTH`, 20, accumulator and result width in bits (two's complement); covers 16368 samples × 9 without saturation.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `sample_valid` input 1: `sample` is valid this cycle.
- `sample` input 5: sign-magnitude product; bit 4 is the sign (1 = negative), bits 3:0 are the magnitude 0..9.
- `dump` input 1: single-cycle epoch strobe.
- `result` output ACC_WIDTH: held accumulated value, signed.
- `result_valid` output 1: `result` holds an unconsumed value.
- `result_ack` input 1: consumer has taken `result`.
- `overrun` output 1: sticky flag; a dump replaced an unacked result.
- `saturated` output 1: sticky flag; the current `result` was clipped during its integration.

## Operation
- FSM states:
  - SYNC (reset state): samples are discarded and the accumulator is held at 0. A `dump` moves to ACCUM without producing a result, because a partial first period is meaningless.
  - ACCUM: each valid sample is added into the accumulator. A `dump` produces a result and stays in ACCUM.
- Conversion from sign-magnitude:
  - Value = sign ? −mag : +mag, sign-extended to ACC_WIDTH.
  - Negative zero (5'b10000) counts as 0.
  - Magnitudes 10..15 are accepted as-is; they are out of spec from the multiplier.
- Saturation:
  - Sum limits are +(2^(ACC_WIDTH−1)−1) and −(2^(ACC_WIDTH−1)−1); the sum is symmetric, so the most-negative code is never produced.
  - Any clip sets an internal `sat_pending` bit.
  - `sat_pending` is transferred to `saturated` on dump and cleared with the accumulator.
- Dump in ACCUM:
  - `result` ← accumulator plus the same-cycle sample, if `sample_valid`. The boundary sample belongs to the closing period.
  - The accumulator ← 0.
  - `result_valid` ← 1.
- Handshake:
  - `result_valid` clears on the cycle after `result_ack` is sampled high while valid.
  - `result_ack` while not valid is ignored.
  - `result` is stable while `result_valid` is high, except when replaced by a dump.
- Dump while `result_valid` is high with no ack the same cycle:
  - `result` is overwritten and `result_valid` stays 1.
  - `overrun` ← 1 and stays set until the next accepted ack.
- Dump and ack in the same cycle: the new result is loaded, `result_valid` stays 1, and `overrun` is not set.
- Reset mid-operation:
  - All state is cleared asynchronously and the FSM returns to SYNC.
  - A pending result is lost.

## Timing
- Reset values: `result` = 0, `result_valid` = 0, `overrun` = 0, `saturated` = 0, accumulator = 0, FSM = SYNC.
- Sample to accumulator: 1 cycle; it is a registered add.
- Dump to output: `result` and `result_valid` update on the edge where `dump` is sampled and are visible the following cycle.
- Throughput: one sample per cycle with no bubbles, including across a dump.
- No combinational path from any input to any output.

## Structure
- Shared tracking package holds:
  - `SM_SAMPLE_WIDTH` = 5 and `SM_MAG_WIDTH` = 4, shared with the multiplier.
  - FSM state encoding (SYNC, ACCUM).
- One sub-module, `sm_to_twos`: a combinational sign-magnitude to two's-complement converter, parameterized on output width. It is reused by the other correlator arms.
- The saturating add and the handshake register live in `carrier_accumulator`.

## Test plan
- Reset, then 5 valid samples of +9 before any dump, then a dump → no result; `result_valid` stays 0; FSM is in ACCUM.
- After sync: 100 samples of +3 (5'b00011) and 50 samples of −2 (5'b10010), then a dump → `result` = 200, `result_valid` = 1 the next cycle. A further dump with no samples in between, after ack → `result` = 0.
- Dump with a same-cycle valid sample of −9 after 10 samples of +1 → `result` = 1. The next period starts from 0, so that −9 is not counted twice.
- Negative-zero samples only (5'b10000 × 20), then a dump → `result` = 0.
- ACC_WIDTH = 6 with 10 samples of +9 → `result` = 31 and `saturated` = 1. The next period of +1 × 3 → `result` = 3 and `saturated` = 0.
- Two dumps without an ack → second value held and `overrun` = 1. Ack → `result_valid` = 0 and `overrun` = 0. Dump and ack in the same cycle → `result_valid` stays 1 and `overrun` stays 0.
- Assert `reset_n` low mid-period with `result_valid` = 1 → all outputs 0 immediately (asynchronous). After release, the first dump yields no result.

Source files
------------

// File: rtl/carrier_accumulator_pkg.sv
// Shared tracking definitions: sign-magnitude product widths used by the
// carrier wipe-off multiplier and the integrate-and-dump FSM encoding.
package carrier_accumulator_pkg;

  localparam int SM_SAMPLE_WIDTH = 5;
  localparam int SM_MAG_WIDTH    = 4;

  typedef enum logic {
    SYNC  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/carrier_accumulator_sm_to_twos.sv
// Combinational sign-magnitude to two's-complement converter, sign-extended
// to OUT_WIDTH bits; negative zero maps to 0.
module sm_to_twos
  import carrier_accumulator_pkg::*;
#(
  parameter int OUT_WIDTH = 20
) (
  input  logic        [SM_SAMPLE_WIDTH-1:0] sm,
  output logic signed [OUT_WIDTH-1:0]       value
);

  logic signed [OUT_WIDTH-1:0] mag_ext;

  always_comb begin
    mag_ext = {{(OUT_WIDTH-SM_MAG_WIDTH){1'b0}}, sm[SM_MAG_WIDTH-1:0]};
    value   = sm[SM_SAMPLE_WIDTH-1] ? -mag_ext : mag_ext;
  end

endmodule

// File: rtl/carrier_accumulator.sv
// Integrate-and-dump stage: saturating running sum of converted products,
// dumped into a held result register with a valid/ack handshake.
module carrier_accumulator
  import carrier_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_valid,
  input  logic [SM_SAMPLE_WIDTH-1:0]  sample,
  input  logic                        dump,
  output logic signed [ACC_WIDTH-1:0] result,
  output logic                        result_valid,
  input  logic                        result_ack,
  output logic                        overrun,
  output logic                        saturated
);

  // Symmetric limits, so the most-negative code is never produced.
  localparam logic signed [ACC_WIDTH:0] SUM_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SUM_MIN = -SUM_MAX;

  acc_state_t                  state_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic                        sat_pending_reg;

  logic signed [ACC_WIDTH-1:0] conv_value;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH:0]   sum_wide;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic                        clip_next;
  logic                        ack_taken;

  sm_to_twos #(
    .OUT_WIDTH(ACC_WIDTH)
  ) u_sm_to_twos (
    .sm   (sample),
    .value(conv_value)
  );

  always_comb begin
    addend    = sample_valid ? conv_value : '0;
    sum_wide  = {acc_reg[ACC_WIDTH-1], acc_reg} + {addend[ACC_WIDTH-1], addend};
    sum_next  = sum_wide[ACC_WIDTH-1:0];
    clip_next = 1'b0;
    if (sum_wide > SUM_MAX) begin
      sum_next  = SUM_MAX[ACC_WIDTH-1:0];
      clip_next = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      sum_next  = SUM_MIN[ACC_WIDTH-1:0];
      clip_next = 1'b1;
    end
    ack_taken = result_valid & result_ack;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= SYNC;
      acc_reg         <= '0;
      sat_pending_reg <= 1'b0;
      result          <= '0;
      result_valid    <= 1'b0;
      overrun         <= 1'b0;
      saturated       <= 1'b0;
    end else begin
      if (ack_taken) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
      end
      case (state_reg)
        SYNC: begin
          // The first period is partial, so nothing is integrated until a dump aligns us.
          acc_reg         <= '0;
          sat_pending_reg <= 1'b0;
          if (dump) state_reg <= ACCUM;
        end
        ACCUM: begin
          if (dump) begin
            // The boundary sample closes the period being dumped.
            result          <= sum_next;
            result_valid    <= 1'b1;
            saturated       <= sat_pending_reg | clip_next;
            acc_reg         <= '0;
            sat_pending_reg <= 1'b0;
            if (result_valid && !result_ack) overrun <= 1'b1;
          end else begin
            acc_reg         <= sum_next;
            sat_pending_reg <= sat_pending_reg | clip_next;
          end
        end
        default: state_reg <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_carrier_accumulator.sv
// Directed bench for carrier_accumulator: a 20-bit instance for the main
// behaviour and a 6-bit instance for saturation.
module tb_carrier_accumulator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               sample_valid = 1'b0;
  logic [4:0]         sample = '0;
  logic               dump = 1'b0;
  logic               result_ack = 1'b0;
  logic signed [19:0] result;
  logic               result_valid, overrun, saturated;

  logic               s6_valid = 1'b0;
  logic [4:0]         s6_sample = '0;
  logic               s6_dump = 1'b0;
  logic               s6_ack = 1'b0;
  logic signed [5:0]  s6_result;
  logic               s6_result_valid, s6_overrun, s6_saturated;

  int n_tests = 0;
  int n_fail  = 0;

  carrier_accumulator #(.ACC_WIDTH(20)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample(sample),
    .dump(dump), .result(result), .result_valid(result_valid),
    .result_ack(result_ack), .overrun(overrun), .saturated(saturated)
  );

  carrier_accumulator #(.ACC_WIDTH(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .sample_valid(s6_valid), .sample(s6_sample),
    .dump(s6_dump), .result(s6_result), .result_valid(s6_result_valid),
    .result_ack(s6_ack), .overrun(s6_overrun), .saturated(s6_saturated)
  );

  task automatic step(input logic v, input logic [4:0] s, input logic d, input logic a);
    sample_valid = v; sample = s; dump = d; result_ack = a;
    @(posedge clk); #1;
    sample_valid = 1'b0; sample = '0; dump = 1'b0; result_ack = 1'b0;
  endtask

  task automatic run(input int n, input logic [4:0] s);
    repeat (n) step(1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic step6(input logic v, input logic [4:0] s, input logic d, input logic a);
    s6_valid = v; s6_sample = s; s6_dump = d; s6_ack = a;
    @(posedge clk); #1;
    s6_valid = 1'b0; s6_sample = '0; s6_dump = 1'b0; s6_ack = 1'b0;
  endtask

  task automatic run6(input int n, input logic [4:0] s);
    repeat (n) step6(1'b1, s, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (result !== 20'sd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_tests++; if (saturated !== 1'b0) begin n_fail++; $display("FAIL reset_saturated: got %b expected 0", saturated); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_sync_discard;
    run(5, 5'b01001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL sync_dump_valid: got %b expected 0", result_valid); end
    step(1'b0, 5'b0, 1'b0, 1'b0);
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL sync_hold_valid: got %b expected 0", result_valid); end
    n_tests++; if (result !== 20'sd0) begin n_fail++; $display("FAIL sync_result: got %0d expected 0", result); end
    $display("[TB] test_sync_discard done");
  endtask

  task automatic test_accumulate;
    run(100, 5'b00011);
    run(50, 5'b10010);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd200) begin n_fail++; $display("FAIL accum_result: got %0d expected 200", result); end
    n_tests++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL accum_valid: got %b expected 1", result_valid); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL accum_ack_valid: got %b expected 0", result_valid); end
    n_tests++; if (result !== 20'sd200) begin n_fail++; $display("FAIL accum_held: got %0d expected 200", result); end
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd0) begin n_fail++; $display("FAIL accum_empty: got %0d expected 0", result); end
    n_tests++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL accum_empty_valid: got %b expected 1", result_valid); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    $display("[TB] test_accumulate done");
  endtask

  task automatic test_boundary;
    run(10, 5'b00001);
    step(1'b1, 5'b11001, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd1) begin n_fail++; $display("FAIL boundary_result: got %0d expected 1", result); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd0) begin n_fail++; $display("FAIL boundary_next: got %0d expected 0", result); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    $display("[TB] test_boundary done");
  endtask

  task automatic test_neg_zero;
    run(7, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd7) begin n_fail++; $display("FAIL negzero_pre: got %0d expected 7", result); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    run(20, 5'b10000);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd0) begin n_fail++; $display("FAIL negzero_result: got %0d expected 0", result); end
    n_tests++; if (saturated !== 1'b0) begin n_fail++; $display("FAIL negzero_saturated: got %b expected 0", saturated); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    $display("[TB] test_neg_zero done");
  endtask

  task automatic test_overrun;
    run(3, 5'b00010);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got %b expected 0", overrun); end
    run(4, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd4) begin n_fail++; $display("FAIL ovr_result: got %0d expected 4", result); end
    n_tests++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", result_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b expected 0", result_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_flag: got %b expected 0", overrun); end
    run(2, 5'b00011);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    run(1, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b1);
    n_tests++; if (result !== 20'sd1) begin n_fail++; $display("FAIL dumpack_result: got %0d expected 1", result); end
    n_tests++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL dumpack_valid: got %b expected 1", result_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL dumpack_overrun: got %b expected 0", overrun); end
    step(1'b0, 5'b0, 1'b0, 1'b1);
    $display("[TB] test_overrun done");
  endtask

  task automatic test_saturation;
    step6(1'b0, 5'b0, 1'b1, 1'b0);
    run6(10, 5'b01001);
    step6(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (s6_result !== 6'sd31) begin n_fail++; $display("FAIL sat_pos_result: got %0d expected 31", s6_result); end
    n_tests++; if (s6_saturated !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag: got %b expected 1", s6_saturated); end
    step6(1'b0, 5'b0, 1'b0, 1'b1);
    run6(3, 5'b00001);
    step6(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (s6_result !== 6'sd3) begin n_fail++; $display("FAIL sat_next_result: got %0d expected 3", s6_result); end
    n_tests++; if (s6_saturated !== 1'b0) begin n_fail++; $display("FAIL sat_next_flag: got %b expected 0", s6_saturated); end
    step6(1'b0, 5'b0, 1'b0, 1'b1);
    run6(10, 5'b11001);
    step6(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (s6_result !== -6'sd31) begin n_fail++; $display("FAIL sat_neg_result: got %0d expected -31", s6_result); end
    n_tests++; if (s6_saturated !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag: got %b expected 1", s6_saturated); end
    step6(1'b0, 5'b0, 1'b0, 1'b1);
    $display("[TB] test_saturation done");
  endtask

  task automatic test_reset_async;
    run(2, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    run(1, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL rst_pre_overrun: got %b expected 1", overrun); end
    run(3, 5'b00001);
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (result !== 20'sd0) begin n_fail++; $display("FAIL rst_async_result: got %0d expected 0", result); end
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", result_valid); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_async_overrun: got %b expected 0", overrun); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run(3, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_first_dump: got %b expected 0", result_valid); end
    run(2, 5'b00001);
    step(1'b0, 5'b0, 1'b1, 1'b0);
    n_tests++; if (result !== 20'sd2) begin n_fail++; $display("FAIL rst_second_dump: got %0d expected 2", result); end
    n_tests++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL rst_second_valid: got %b expected 1", result_valid); end
    $display("[TB] test_reset_async done");
  endtask

  initial begin
    test_reset();
    test_sync_discard();
    test_accumulate();
    test_boundary();
    test_neg_zero();
    test_overrun();
    test_saturation();
    test_reset_async();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
